// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per clock, Start/Done handshake.
// Optional macro SUBTRACT_EN enables Sub (A - B - borrow-in) by inverting B and CarryIn on capture.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] INa,
  input  logic [WIDTH-1:0] INb,
  input  logic             CarryIn,
  input  logic             Sub,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned CntW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q, done_q, ready_q;

  logic [DIGIT-1:0]       a_dig, b_dig;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic [WIDTH-1:0]       b_cap;
  logic                   c_cap, last_dig, ovf_dig;

`ifdef SUBTRACT_EN
  assign b_cap = Sub ? ~INb : INb;
  assign c_cap = Sub ? ~CarryIn : CarryIn;
`else
  logic unused_sub;
  assign b_cap      = INb;
  assign c_cap      = CarryIn;
  assign unused_sub = Sub;
`endif

  always_comb begin
    a_dig    = a_q[DIGIT-1:0];
    b_dig    = b_q[DIGIT-1:0];
    slice    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Digit sum enters from the MSB side; after NUM_DIGITS shifts the result is aligned.
    res_cat  = {slice[DIGIT-1:0], res_q};
    res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    // a^b^s at the top bit recovers the carry into it; XOR with carry out gives overflow.
    ovf_dig  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
    last_dig = (cnt_q == CntW'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            a_q     <= INa;
            b_q     <= b_cap;
            carry_q <= c_cap;
            res_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= slice[DIGIT];
          cnt_q   <= cnt_q + CntW'(1);
          if (last_dig) begin
            sum_q   <= res_next;
            cout_q  <= slice[DIGIT];
            ovf_q   <= ovf_dig;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign Sum      = sum_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;

endmodule
